// File: rtl/ofdm_tx_frame_serializer_if.sv
// Frame-in / symbol-out stream bundle for the OFDM Tx frame serializer.
// The master drives frames and the symbol ready; the slave is the serializer itself.
interface ofdm_tx_frame_serializer_if #(
    parameter int FRAME_W = 224,
    parameter int SYM_W   = 1
);
    logic [FRAME_W-1:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic [SYM_W-1:0]   m_data;
    logic               m_valid;
    logic               m_last;
    logic               m_ready;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/ofdm_tx_frame_serializer.sv
// Double-buffered frame-to-symbol serializer feeding the OFDM Tx mapper.
// Two ping-pong frame slots let the next frame load while the current one drains.
module ofdm_tx_frame_serializer #(
    parameter int FRAME_W   = 224,
    parameter int SYM_W     = 1,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 flush,
    ofdm_tx_frame_serializer_if.slave bus,
    output logic [1:0]           frames_pend,
    output logic [CNT_W-1:0]     frames_sent
);
    localparam int BEATS = FRAME_W / SYM_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (FRAME_W % SYM_W != 0) begin : g_bad_width
            $error("FRAME_W must be an integer multiple of SYM_W");
        end
    endgenerate

    logic [FRAME_W-1:0] slot [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic [IDX_W-1:0]   idx;

    logic               accept;
    logic               beat;
    logic               last_beat;
    logic [FRAME_W-1:0] cur_frame;
    logic [FRAME_W-1:0] shifted;
    logic [31:0]        bit_base;

    assign bus.s_ready = nreset && (count < 2'd2);
    assign bus.m_valid = (count != 2'd0);
    assign bus.m_last  = bus.m_valid && (idx == IDX_W'(BEATS - 1));
    assign frames_pend = count;

    assign accept    = bus.s_valid && bus.s_ready;
    assign beat      = bus.m_valid && bus.m_ready;
    assign last_beat = beat && bus.m_last;

    // Beat selection shifts the active slot so the wanted symbol lands at a fixed end.
    always_comb begin
        cur_frame = slot[rd_ptr];
        bit_base  = 32'(idx) * 32'(SYM_W);
        shifted   = '0;
        bus.m_data = '0;
        if (MSB_FIRST) begin
            shifted    = cur_frame << bit_base;
            bus.m_data = shifted[FRAME_W-1 -: SYM_W];
        end else begin
            shifted    = cur_frame >> bit_base;
            bus.m_data = shifted[SYM_W-1:0];
        end
        if (!bus.m_valid) begin
            bus.m_data = '0;
        end
    end

    // Slot storage carries no reset; a flushed or reset cycle simply never writes it.
    always_ff @(posedge clk) begin
        if (nreset && !flush && accept) begin
            slot[wr_ptr] <= bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            idx         <= '0;
            frames_sent <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            idx    <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (beat) begin
                if (last_beat) begin
                    idx         <= '0;
                    rd_ptr      <= ~rd_ptr;
                    frames_sent <= frames_sent + CNT_W'(1);
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            case ({accept, last_beat})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_ofdm_tx_frame_serializer.sv
// Directed bench for the frame serializer: one LSB-first 1-bit instance and one
// MSB-first 2-bit instance, covering latency, back-pressure, flush and mid-frame reset.
module tb_ofdm_tx_frame_serializer;
    localparam int FRAME_W = 224;
    localparam int BEATS1  = 224;
    localparam int BEATS2  = 112;

    logic        clk = 1'b0;
    logic        nreset;
    logic        flush1;
    logic        flush2;
    logic [1:0]  pend1;
    logic [1:0]  pend2;
    logic [15:0] sent1;
    logic [15:0] sent2;

    ofdm_tx_frame_serializer_if #(.FRAME_W(FRAME_W), .SYM_W(1)) bus1();
    ofdm_tx_frame_serializer_if #(.FRAME_W(FRAME_W), .SYM_W(2)) bus2();

    ofdm_tx_frame_serializer #(
        .FRAME_W(FRAME_W), .SYM_W(1), .MSB_FIRST(1'b0), .CNT_W(16)
    ) dut1 (
        .clk(clk), .nreset(nreset), .flush(flush1), .bus(bus1.slave),
        .frames_pend(pend1), .frames_sent(sent1)
    );

    ofdm_tx_frame_serializer #(
        .FRAME_W(FRAME_W), .SYM_W(2), .MSB_FIRST(1'b1), .CNT_W(16)
    ) dut2 (
        .clk(clk), .nreset(nreset), .flush(flush2), .bus(bus2.slave),
        .frames_pend(pend2), .frames_sent(sent2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [FRAME_W-1:0] tx [20];
    logic [FRAME_W-1:0] rx [20];
    int                 acc_cyc [20];
    int                 last_cyc [20];
    int                 gaps;
    logic               sready_after_b;

    task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        nreset       = 1'b0;
        flush1       = 1'b0;
        bus1.s_valid = 1'b0;
        bus1.m_ready = 1'b0;
        bus2.s_valid = 1'b0;
        bus2.m_ready = 1'b0;
        tick();
        check_output("s_ready_in_reset", bus1.s_ready, 0);
        tick();
        nreset = 1'b1;
        #1;
    endtask

    // Drives frames tx[0..n-1] into dut1 while collecting beats into rx[], one cycle per pass.
    task automatic stream_frames(input int n, input bit rand_ready);
        int   n_acc = 0;
        int   n_rx = 0;
        int   bidx = 0;
        int   cyc = 0;
        logic stalled = 1'b0;
        logic prev_data = 1'b0;
        logic prev_last = 1'b0;
        logic rdy;
        gaps = 0;
        sready_after_b = 1'b1;
        for (int i = 0; i < 20; i++) rx[i] = '0;
        while (n_rx < n && cyc < 20000) begin
            if (stalled) begin
                check_output("stall_data", bus1.m_data, prev_data);
                check_output("stall_last", bus1.m_last, prev_last);
            end
            if (n_acc == 2 && cyc == acc_cyc[1] + 1) sready_after_b = bus1.s_ready;
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus1.m_ready = rdy;
            bus1.s_valid = (n_acc < n);
            if (n_acc < n) bus1.s_data = tx[n_acc];
            if (bus1.s_valid && bus1.s_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (!rand_ready && n_acc > 0 && cyc > acc_cyc[0] && !bus1.m_valid) gaps++;
            if (bus1.m_valid && rdy) begin
                rx[n_rx][bidx] = bus1.m_data;
                if (bus1.m_last || bidx == BEATS1 - 1) begin
                    check_output("last_pos", bus1.m_last, bidx == BEATS1 - 1);
                    last_cyc[n_rx] = cyc;
                    n_rx++;
                    bidx = 0;
                end else begin
                    bidx++;
                end
            end
            stalled   = bus1.m_valid && !rdy;
            prev_data = bus1.m_data;
            prev_last = bus1.m_last;
            tick();
            cyc++;
        end
        bus1.s_valid = 1'b0;
        bus1.m_ready = 1'b0;
        check_output("stream_done", n_rx, n);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int                 n;
        int                 lastcnt;
        int                 lastpos;
        int                 first_beats [2];
        logic [FRAME_W-1:0] f;
        logic [FRAME_W-1:0] frame_a;
        logic [15:0]        sent_before;

        nreset = 1'b0;
        flush1 = 1'b0;
        flush2 = 1'b0;
        bus1.s_data = '0; bus1.s_valid = 1'b0; bus1.m_ready = 1'b0;
        bus2.s_data = '0; bus2.s_valid = 1'b0; bus2.m_ready = 1'b0;

        apply_reset();
        check_output("rst_m_valid", bus1.m_valid, 0);
        check_output("rst_m_last", bus1.m_last, 0);
        check_output("rst_m_data", bus1.m_data, 0);
        check_output("rst_pend", pend1, 0);
        check_output("rst_sent", sent1, 0);
        check_output("rst_s_ready", bus1.s_ready, 1);

        // T1: LSB-first single-bit stream of 0x5
        $display("[TB] T1 single-bit frame");
        bus1.s_data  = 224'h5;
        bus1.s_valid = 1'b1;
        tick();
        bus1.s_valid = 1'b0;
        check_output("t1_latency_valid", bus1.m_valid, 1);
        check_output("t1_pend", pend1, 1);
        bus1.m_ready = 1'b1;
        n = 0; lastcnt = 0; lastpos = -1; f = '0;
        while (bus1.m_valid && n < 300) begin
            if (n < FRAME_W) f[n] = bus1.m_data;
            if (bus1.m_last) begin
                lastcnt++;
                lastpos = n;
            end
            n++;
            tick();
        end
        bus1.m_ready = 1'b0;
        check_output("t1_beats", n, BEATS1);
        check_output("t1_frame", f, 224'h5);
        check_output("t1_last_count", lastcnt, 1);
        check_output("t1_last_pos", lastpos, BEATS1 - 1);
        check_output("t1_idle_valid", bus1.m_valid, 0);
        check_output("t1_sent", sent1, 1);

        // T2: MSB-first 2-bit symbols on the second instance
        $display("[TB] T2 two-bit MSB-first frame");
        bus2.s_data  = {4'b1001, 216'h0, 4'hC};
        bus2.s_valid = 1'b1;
        tick();
        bus2.s_valid = 1'b0;
        bus2.m_ready = 1'b1;
        n = 0; lastcnt = 0; lastpos = -1; f = '0;
        first_beats[0] = -1; first_beats[1] = -1;
        while (bus2.m_valid && n < 300) begin
            if (n < 2) first_beats[n] = int'(bus2.m_data);
            if (n < BEATS2) f[FRAME_W-1-2*n -: 2] = bus2.m_data;
            if (bus2.m_last) begin
                lastcnt++;
                lastpos = n;
            end
            n++;
            tick();
        end
        bus2.m_ready = 1'b0;
        check_output("t2_beat0", first_beats[0], 2);
        check_output("t2_beat1", first_beats[1], 1);
        check_output("t2_beats", n, BEATS2);
        check_output("t2_last_count", lastcnt, 1);
        check_output("t2_last_pos", lastpos, BEATS2 - 1);
        check_output("t2_frame", f, {4'b1001, 216'h0, 4'hC});
        check_output("t2_sent", sent2, 1);

        // T3: three frames back-to-back with full back-pressure on the input
        $display("[TB] T3 back-to-back frames");
        apply_reset();
        tx[0] = {7{32'hA5A5_0F0F}};
        tx[1] = {7{32'h1234_5678}};
        tx[2] = {7{32'hC3C3_9E01}};
        stream_frames(3, 1'b0);
        for (int i = 0; i < 3; i++) check_output($sformatf("t3_frame%0d", i), rx[i], tx[i]);
        check_output("t3_gaps", gaps, 0);
        check_output("t3_full_s_ready", sready_after_b, 0);
        check_output("t3_c_accept", acc_cyc[2], last_cyc[0] + 1);
        check_output("t3_c_last", last_cyc[2], last_cyc[0] + 2 * BEATS1);
        check_output("t3_sent", sent1, 3);

        // T4: random back-pressure over 20 random frames
        $display("[TB] T4 random back-pressure");
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            tx[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        stream_frames(20, 1'b1);
        for (int i = 0; i < 20; i++) check_output($sformatf("t4_frame%0d", i), rx[i], tx[i]);
        check_output("t4_sent", sent1, 20);

        // T5: flush mid-frame with a second frame pending
        $display("[TB] T5 flush");
        apply_reset();
        frame_a = {7{32'h0F1E_2D3C}};
        bus1.m_ready = 1'b1;
        bus1.s_data  = frame_a;
        bus1.s_valid = 1'b1;
        tick();
        bus1.s_data = {7{32'h5555_AAAA}};
        tick();
        bus1.s_valid = 1'b0;
        for (int k = 1; k < 50; k++) tick();
        check_output("t5_pend_before", pend1, 2);
        check_output("t5_beat50", bus1.m_data, frame_a[50]);
        sent_before = sent1;
        flush1 = 1'b1;
        tick();
        flush1 = 1'b0;
        bus1.m_ready = 1'b0;
        check_output("t5_m_valid", bus1.m_valid, 0);
        check_output("t5_pend", pend1, 0);
        check_output("t5_s_ready", bus1.s_ready, 1);
        check_output("t5_sent", sent1, sent_before);
        tx[0] = {7{32'hDEAD_BEEF}};
        stream_frames(1, 1'b0);
        check_output("t5_frame_d", rx[0], tx[0]);
        check_output("t5_sent_after", sent1, 1);

        // T6: one-cycle reset in the middle of a frame
        $display("[TB] T6 mid-frame reset");
        bus1.s_data  = {7{32'h7777_1111}};
        bus1.s_valid = 1'b1;
        tick();
        bus1.s_valid = 1'b0;
        bus1.m_ready = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        nreset = 1'b0;
        #1;
        check_output("t6_s_ready_low", bus1.s_ready, 0);
        tick();
        nreset = 1'b1;
        #1;
        check_output("t6_m_valid", bus1.m_valid, 0);
        check_output("t6_m_last", bus1.m_last, 0);
        check_output("t6_m_data", bus1.m_data, 0);
        check_output("t6_pend", pend1, 0);
        check_output("t6_sent", sent1, 0);
        check_output("t6_s_ready", bus1.s_ready, 1);
        lastcnt = 0;
        for (int k = 0; k < 250; k++) begin
            if (bus1.m_last) lastcnt++;
            tick();
        end
        bus1.m_ready = 1'b0;
        check_output("t6_no_last", lastcnt, 0);
        tx[0] = {7{32'h0BAD_F00D}};
        stream_frames(1, 1'b0);
        check_output("t6_frame_f", rx[0], tx[0]);
        check_output("t6_sent_after", sent1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
